product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/prod_acc_pkg.sv | 23 ++
 rtl/prod_acc_if.sv | 47 ++++
 rtl/acc_adder.sv | 48 ++++
 rtl/product_accumulator.sv | 131 +++++++++++++
 tb/tb_product_accumulator.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prod_acc_pkg.sv
// ---------------------------------------------------------------------------
// prod_acc_pkg
// Shared constants and types for the product accumulator slice.
//   PROD_W   : width of one incoming product (upstream 4x4 multiplier)
//   CNT_W    : width of the per-batch transfer counter
//   state_t  : FSM state encoding (ACC = collecting, DONE = result pending)
//   last_cnt : counter value that marks the final transfer of a batch
// ---------------------------------------------------------------------------
package prod_acc_pkg;

  localparam int PROD_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] last_cnt(input int len);
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/prod_acc_if.sv
// ---------------------------------------------------------------------------
// prod_acc_if
// Handshake bundle between the upstream product source, the accumulator and
// the downstream consumer of batch sums.
//   in_valid / in_ready / in_prod        : product stream into the block
//   out_valid / out_ready / out_sum /
//   out_ovf                              : batch result out of the block
// Modports:
//   master : the environment (drives products and out_ready)
//   slave  : the accumulator (drives in_ready and the result)
// Parameter ACC_W must match the ACC_W of the attached accumulator.
// ---------------------------------------------------------------------------
interface prod_acc_if
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = 12
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output in_valid,
    output in_prod,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_prod,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_ovf
  );

endinterface

// File: rtl/acc_adder.sv
// ---------------------------------------------------------------------------
// acc_adder
// Combinational next-value logic for the batch accumulator: adds one
// zero-extended product to the running sum.
//   acc      : current accumulator value (ACC_W bits)
//   prod     : incoming product (PROD_W bits, unsigned)
//   next_acc : accumulator value after this product
//   ovf      : (PROD_ACC_SAT_EN only) the true sum did not fit in ACC_W bits
// Build option:
//   PROD_ACC_SAT_EN defined   -> clamp at 2^ACC_W-1 and report ovf
//   PROD_ACC_SAT_EN undefined -> wrap modulo 2^ACC_W, no ovf port
// ---------------------------------------------------------------------------
module acc_adder
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
`ifdef PROD_ACC_SAT_EN
  output logic              ovf,
`endif
  output logic [ACC_W-1:0]  next_acc
);

`ifdef PROD_ACC_SAT_EN
  // One extra bit catches the carry-out; a set carry means the sum has
  // left the representable range and is pinned to all ones.
  logic [ACC_W:0] sum;

  always_comb begin
    sum = {1'b0, acc} + (ACC_W + 1)'(prod);
    if (sum[ACC_W]) begin
      next_acc = '1;
      ovf      = 1'b1;
    end else begin
      next_acc = sum[ACC_W-1:0];
      ovf      = 1'b0;
    end
  end
`else
  // Plain modular addition; the carry-out is simply dropped.
  always_comb begin
    next_acc = acc + ACC_W'(prod);
  end
`endif

endmodule

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// Sums LEN consecutive unsigned products into one batch result and hands it
// downstream with a valid/ready handshake.
// Parameters:
//   LEN   : products per batch (1..15)
//   ACC_W : accumulator / result width (8..16)
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : prod_acc_if slave modport (product input + batch result output)
// Behaviour:
//   ACC  : in_ready=1, out_valid=0, out_sum shows the running sum.
//   DONE : in_ready=0, out_valid=1, result held until out_ready=1, after
//          which the block clears and returns to ACC (no input accepted in
//          the handshake cycle, so a one-cycle bubble always follows).
// Build option:
//   PROD_ACC_SAT_EN : saturate instead of wrap, sticky overflow on out_ovf.
//                     When undefined out_ovf is constant 0.
// ---------------------------------------------------------------------------
module product_accumulator
  import prod_acc_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 12
) (
  input  logic      clk,
  input  logic      rst,
  prod_acc_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = last_cnt(LEN);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             drain;
  logic             last;

`ifdef PROD_ACC_SAT_EN
  logic             add_ovf;
  logic             ovf_flag;
`endif

  acc_adder #(
    .ACC_W    (ACC_W)
  ) u_adder (
    .acc      (acc),
    .prod     (bus.in_prod),
`ifdef PROD_ACC_SAT_EN
    .ovf      (add_ovf),
`endif
    .next_acc (acc_sum)
  );

  // Handshake decode, next-state selection and output drive. A transfer can
  // only happen in ACC and a drain only in DONE, so the two never coincide.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_sum   = acc;
    xfer          = 1'b0;
    drain         = 1'b0;
    last          = (cnt == LAST);

    case (state)
      ACC: begin
        bus.in_ready = 1'b1;
        xfer         = bus.in_valid;
        if (xfer && last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        drain         = bus.out_ready;
        if (drain) begin
          state_next = ACC;
        end
      end
      default: begin
        state_next = ACC;
      end
    endcase

`ifdef PROD_ACC_SAT_EN
    bus.out_ovf = ovf_flag;
`else
    bus.out_ovf = 1'b0;
`endif
  end

  // State, sum and counter. The counter rolls back to zero on the final
  // transfer so it never reaches LEN; the sum is kept for the DONE phase
  // and only cleared once the result has been taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (xfer) begin
        acc <= acc_sum;
        cnt <= last ? '0 : cnt + CNT_W'(1);
      end else if (drain) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

`ifdef PROD_ACC_SAT_EN
  // Overflow is sticky for the whole batch: once any addition clamps, the
  // final result is flagged even if later products were zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (xfer) begin
      ovf_flag <= ovf_flag | add_ovf;
    end else if (drain) begin
      ovf_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
// Self-checking bench for product_accumulator. Three instances cover the
// LEN=4/ACC_W=12, LEN=8/ACC_W=10 and LEN=1/ACC_W=12 configurations.
// Expected batch results are queued when stimulus is driven and popped when
// the DUT completes an output handshake. Inputs change 1 ns after a rising
// edge; outputs are sampled on the falling edge.
// Honours PROD_ACC_SAT_EN for the saturating build.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

  typedef struct {
    logic [15:0] sum;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [3:0][7:0] prod;
    bit              gap;
    logic [15:0]     exp_sum;
  } vec_t;

  logic clk = 1'b0;
  logic rst4;
  logic rst8;
  logic rst1;

  int total = 0;
  int bad   = 0;

  exp_t q4[$];
  exp_t q8[$];
  exp_t q1[$];

  vec_t vecs[5];

  always #5 clk = ~clk;

  prod_acc_if #(.ACC_W(12)) if4 ();
  prod_acc_if #(.ACC_W(10)) if8 ();
  prod_acc_if #(.ACC_W(12)) if1 ();

  product_accumulator #(.LEN(4), .ACC_W(12)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4.slave)
  );

  product_accumulator #(.LEN(8), .ACC_W(10)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (if8.slave)
  );

  product_accumulator #(.LEN(1), .ACC_W(12)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1.slave)
  );

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Scoreboard: any output handshake about to happen at the next edge pops
  // one expected result for that instance.
  task automatic monitor();
    exp_t e;
    if (!rst4 && if4.out_valid && if4.out_ready) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL sb4_unexpected: got sum %0d expected no result", if4.out_sum);
      end else begin
        e = q4.pop_front();
        check_output("sb4_sum", 16'(if4.out_sum), e.sum);
        check_output("sb4_ovf", 16'(if4.out_ovf), 16'(e.ovf));
      end
    end
    if (!rst8 && if8.out_valid && if8.out_ready) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL sb8_unexpected: got sum %0d expected no result", if8.out_sum);
      end else begin
        e = q8.pop_front();
        check_output("sb8_sum", 16'(if8.out_sum), e.sum);
        check_output("sb8_ovf", 16'(if8.out_ovf), 16'(e.ovf));
      end
    end
    if (!rst1 && if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL sb1_unexpected: got sum %0d expected no result", if1.out_sum);
      end else begin
        e = q1.pop_front();
        check_output("sb1_sum", 16'(if1.out_sum), e.sum);
        check_output("sb1_ovf", 16'(if1.out_ovf), 16'(e.ovf));
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int which, input logic [15:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    if (which == 4) q4.push_back(e);
    else if (which == 8) q8.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic drain_all(input int budget);
    int n = 0;
    while ((q4.size() + q8.size() + q1.size()) > 0 && n < budget) begin
      cycle();
      n++;
    end
    if ((q4.size() + q8.size() + q1.size()) > 0) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout: got %0d results outstanding expected 0",
               q4.size() + q8.size() + q1.size());
      q4.delete(); q8.delete(); q1.delete();
    end
  endtask

  task automatic apply_stimulus4(input logic [7:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      if4.in_valid = 1'b1;
      if4.in_prod  = p;
      cycle();
    end
    if4.in_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   bubbles;
    int   n;
    logic accepted;
    logic [7:0] p1[2];

    vecs[0].prod = {8'd225, 8'd225, 8'd225, 8'd225}; vecs[0].gap = 1'b0; vecs[0].exp_sum = 16'd900;
    vecs[1].prod = {8'd4,   8'd3,   8'd2,   8'd1};   vecs[1].gap = 1'b1; vecs[1].exp_sum = 16'd10;
    vecs[2].prod = {8'd0,   8'd0,   8'd0,   8'd0};   vecs[2].gap = 1'b0; vecs[2].exp_sum = 16'd0;
    vecs[3].prod = {8'd255, 8'd255, 8'd255, 8'd255}; vecs[3].gap = 1'b1; vecs[3].exp_sum = 16'd1020;
    vecs[4].prod = {8'd12,  8'd25,  8'd50,  8'd100}; vecs[4].gap = 1'b0; vecs[4].exp_sum = 16'd187;

    rst4 = 1'b1; rst8 = 1'b1; rst1 = 1'b1;
    if4.in_valid = 1'b0; if4.in_prod = 8'd0; if4.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.in_prod = 8'd0; if8.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_prod = 8'd0; if1.out_ready = 1'b0;

    // Reset values
    cycle();
    cycle();
    rst4 = 1'b0; rst8 = 1'b0; rst1 = 1'b0;
    check_output("rst_in_ready",  16'(if4.in_ready),  16'd1);
    check_output("rst_out_valid", 16'(if4.out_valid), 16'd0);
    check_output("rst_out_sum",   16'(if4.out_sum),   16'd0);
    check_output("rst_out_ovf",   16'(if4.out_ovf),   16'd0);
    check_output("rst8_out_sum",  16'(if8.out_sum),   16'd0);
    check_output("rst1_in_ready", 16'(if1.in_ready),  16'd1);

    // Four transfers of 225, latency and hold while out_ready is low
    if4.out_ready = 1'b0;
    push(4, 16'd900, 1'b0);
    apply_stimulus4(8'd225, 3);
    check_output("pre_last_valid", 16'(if4.out_valid), 16'd0);
    check_output("running_sum",    16'(if4.out_sum),   16'd675);
    apply_stimulus4(8'd225, 1);
    check_output("latency_valid", 16'(if4.out_valid), 16'd1);
    check_output("latency_sum",   16'(if4.out_sum),   16'd900);
    if4.in_valid = 1'b1;
    if4.in_prod  = 8'd50;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_output("hold_in_ready", 16'(if4.in_ready), 16'd0);
      check_output("hold_sum",      16'(if4.out_sum),  16'd900);
    end
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    cycle();
    check_output("release_in_ready",  16'(if4.in_ready),  16'd1);
    check_output("release_out_valid", 16'(if4.out_valid), 16'd0);
    check_output("release_sum",       16'(if4.out_sum),   16'd0);

    // Table-driven batches on the LEN=4 instance
    for (int v = 0; v < 5; v++) begin
      push(4, vecs[v].exp_sum, 1'b0);
      if4.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if4.in_valid = 1'b1;
        if4.in_prod  = vecs[v].prod[k];
        cycle();
        if (vecs[v].gap) begin
          if4.in_valid = 1'b0;
          if4.in_prod  = 8'hAB;
          cycle();
        end
      end
      if4.in_valid = 1'b0;
      drain_all(10);
    end

    // Reset mid-batch: stale partial sum must not leak into the next batch
    apply_stimulus4(8'd200, 2);
    rst4 = 1'b1;
    cycle();
    rst4 = 1'b0;
    check_output("midrst_sum",      16'(if4.out_sum),  16'd0);
    check_output("midrst_in_ready", 16'(if4.in_ready), 16'd1);
    push(4, 16'd4, 1'b0);
    apply_stimulus4(8'd1, 4);
    drain_all(10);

    // Reset while a result is waiting: it is dropped, never presented
    if4.out_ready = 1'b0;
    apply_stimulus4(8'd9, 4);
    check_output("pending_valid", 16'(if4.out_valid), 16'd1);
    rst4 = 1'b1;
    cycle();
    rst4 = 1'b0;
    check_output("dropped_valid", 16'(if4.out_valid), 16'd0);
    check_output("dropped_sum",   16'(if4.out_sum),   16'd0);
    if4.out_ready = 1'b1;
    cycle();
    cycle();

    // LEN=8, ACC_W=10: eight transfers of 225 overflow the 10-bit sum
    if8.out_ready = 1'b1;
`ifdef PROD_ACC_SAT_EN
    push(8, 16'd1023, 1'b1);
`else
    push(8, 16'd776, 1'b0);
`endif
    for (int k = 0; k < 8; k++) begin
      if8.in_valid = 1'b1;
      if8.in_prod  = 8'd225;
      cycle();
    end
    if8.in_valid = 1'b0;
    drain_all(10);
    push(8, 16'd80, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if8.in_valid = 1'b1;
      if8.in_prod  = 8'd10;
      cycle();
    end
    if8.in_valid = 1'b0;
    drain_all(10);

    // LEN=1: back-to-back 7 then 9, expect one in_ready bubble between
    if1.out_ready = 1'b1;
    p1[0] = 8'd7;
    p1[1] = 8'd9;
    push(1, 16'd7, 1'b0);
    push(1, 16'd9, 1'b0);
    bubbles = 0;
    for (int idx = 0; idx < 2; idx++) begin
      if1.in_valid = 1'b1;
      if1.in_prod  = p1[idx];
      accepted = 1'b0;
      n = 0;
      while (!accepted && n < 10) begin
        accepted = if1.in_ready;
        if (!accepted && idx == 1) bubbles++;
        cycle();
        n++;
      end
      if (!accepted) begin
        total++; bad++;
        $display("[TB] FAIL len1_accept: got no in_ready expected acceptance of %0d", p1[idx]);
      end
    end
    if1.in_valid = 1'b0;
    drain_all(10);
    check_output("len1_bubbles", 16'(bubbles), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
